// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage pipeline register for the five-stage core (IF/ID,
//   ID/EX, EX/MEM, MEM/WB). It carries a PC plus an opaque payload between
//   stages. It provides a valid/ready handshake, a synchronous flush, an
//   optional 2-entry skid buffer and a saturating stall counter.
//
// Parameters
//   DATA_W   payload width (packed control + data fields)
//   PC_W     PC field width
//   SKID_EN  1: 2-entry skid buffer, ready_o decoded from state only
//            0: single entry, ready_o = ~valid_o | ready_i (combinational)
//   CNT_W    stall counter width
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-low reset
//   flush_i      synchronous flush: drop held and incoming entries
//   valid_i      upstream presents an entry
//   ready_o      this stage can accept an entry
//   pc_i/data_i  upstream PC / payload
//   valid_o      an entry is presented downstream
//   ready_i      downstream can accept
//   pc_o/data_o  PC / payload of the head (main) entry
//   occupancy_o  number of held entries (0..2)
//   stall_cnt_o  saturating count of cycles with valid_o=1 and ready_i=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 72,
  parameter int unsigned PC_W    = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stateE;

  stateE             state;
  stateE             nextState;

  logic [PC_W-1:0]   mainPc;
  logic [DATA_W-1:0] mainData;
  logic [PC_W-1:0]   skidPc;
  logic [DATA_W-1:0] skidData;
  logic [CNT_W-1:0]  stallCnt;

  logic              accept;
  logic              issue;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;
  logic              clearAll;
  logic              stallInc;

  // Output decode: the head entry always lives in the main register.
  assign valid_o     = (state != EMPTY);
  assign pc_o        = mainPc;
  assign data_o      = mainData;
  assign stall_cnt_o = stallCnt;

  // With the skid buffer, ready depends on state only, which breaks the
  // ready_i -> ready_o timing path across a chain of stages.
  assign ready_o = SKID_EN ? (state != SKID) : (~valid_o | ready_i);

  assign accept   = valid_i & ready_o;
  assign issue    = valid_o & ready_i;
  assign stallInc = valid_o & ~ready_i & ~flush_i;

  always_comb begin
    occupancy_o = 2'd0;
    case (state)
      FULL:    occupancy_o = 2'd1;
      SKID:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  // Next-state and register-load decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    clearAll     = 1'b0;
    if (flush_i) begin
      // The head may still issue this cycle; flush only kills what follows.
      nextState = EMPTY;
      clearAll  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState  = FULL;
            loadMainIn = 1'b1;
          end
        end
        FULL: begin
          if (accept && issue) begin
            loadMainIn = 1'b1;
          end else if (accept && SKID_EN) begin
            // Downstream stalled: park the new entry behind the head.
            nextState = SKID;
            loadSkid  = 1'b1;
          end else if (issue) begin
            nextState = EMPTY;
          end
        end
        SKID: begin
          // ready_o is low here, so only the head can move; the skid entry
          // is promoted to keep strict FIFO order.
          if (issue) begin
            nextState    = FULL;
            loadMainSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      mainPc   <= '0;
      mainData <= '0;
      skidPc   <= '0;
      skidData <= '0;
      stallCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= nextState;
      if (clearAll) begin
        mainPc   <= '0;
        mainData <= '0;
        skidPc   <= '0;
        skidData <= '0;
      end else begin
        if (loadMainIn) begin
          mainPc   <= pc_i;
          mainData <= data_i;
        end else if (loadMainSkid) begin
          mainPc   <= skidPc;
          mainData <= skidData;
        end
        if (loadSkid) begin
          skidPc   <= pc_i;
          skidData <= data_i;
        end
      end
      // Saturate rather than wrap so a long stall never reads as short.
      if (stallInc && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Instance dutA uses the skid buffer
//   with a 4-bit stall counter; instance dutB has no skid buffer. Expected
//   entries are queued when the stimulus offers an entry that must be
//   accepted; a monitor per instance pops and compares on every issue.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [71:0] data;
  } entryT;

  logic        clk = 1'b0;
  logic        rst;

  // dutA: SKID_EN=1, CNT_W=4
  logic        flushA, vInA, rdyOutA, vOutA, rdyInA;
  logic [31:0] pcInA, pcOutA;
  logic [71:0] dInA, dOutA;
  logic [1:0]  occA;
  logic [3:0]  stallA;

  // dutB: SKID_EN=0, CNT_W=16
  logic        flushB, vInB, rdyOutB, vOutB, rdyInB;
  logic [31:0] pcInB, pcOutB;
  logic [71:0] dInB, dOutB;
  logic [1:0]  occB;
  logic [15:0] stallB;

  entryT qA[$];
  entryT qB[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(72), .PC_W(32), .SKID_EN(1'b1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .flush_i(flushA), .valid_i(vInA), .ready_o(rdyOutA),
    .pc_i(pcInA), .data_i(dInA), .valid_o(vOutA), .ready_i(rdyInA),
    .pc_o(pcOutA), .data_o(dOutA), .occupancy_o(occA), .stall_cnt_o(stallA)
  );

  pipe_stage_reg #(.DATA_W(72), .PC_W(32), .SKID_EN(1'b0), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .flush_i(flushB), .valid_i(vInB), .ready_o(rdyOutB),
    .pc_i(pcInB), .data_i(dInB), .valid_o(vOutB), .ready_i(rdyInB),
    .pc_o(pcOutB), .data_o(dOutB), .occupancy_o(occB), .stall_cnt_o(stallB)
  );

  function automatic logic [71:0] dataOf(input logic [31:0] pc);
    return {8'hA5, pc ^ 32'hDEADBEEF, pc};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an entry to dutA; queue it when it must be accepted.
  task automatic offerA(input logic [31:0] pc, input bit expAccept);
    vInA  = 1'b1;
    pcInA = pc;
    dInA  = dataOf(pc);
    if (expAccept) qA.push_back('{pc: pc, data: dataOf(pc)});
  endtask

  task automatic offerB(input logic [31:0] pc);
    vInB  = 1'b1;
    pcInB = pc;
    dInB  = dataOf(pc);
    qB.push_back('{pc: pc, data: dataOf(pc)});
  endtask

  // Monitors: sampled mid-cycle, an issue happens at the next rising edge.
  always @(negedge clk) begin
    entryT e;
    if (rst && vOutA && rdyInA) begin
      if (qA.size() == 0) begin
        check("A_unexpected_issue_pc", {40'd0, pcOutA}, 72'hFFFF_FFFF_FFFF_FFFF_FF);
      end else begin
        e = qA.pop_front();
        check("A_issue_pc", {40'd0, pcOutA}, {40'd0, e.pc});
        check("A_issue_data", dOutA, e.data);
      end
    end
  end

  always @(negedge clk) begin
    entryT e;
    if (rst && vOutB && rdyInB) begin
      if (qB.size() == 0) begin
        check("B_unexpected_issue_pc", {40'd0, pcOutB}, 72'hFFFF_FFFF_FFFF_FFFF_FF);
      end else begin
        e = qB.pop_front();
        check("B_issue_pc", {40'd0, pcOutB}, {40'd0, e.pc});
        check("B_issue_data", dOutB, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flushA = 1'b0; vInA = 1'b0; rdyInA = 1'b0; pcInA = '0; dInA = '0;
    flushB = 1'b0; vInB = 1'b0; rdyInB = 1'b0; pcInB = '0; dInB = '0;

    // Reset state
    #12;
    check("rst_valid", 72'(vOutA), 72'd0);
    check("rst_ready", 72'(rdyOutA), 72'd1);
    check("rst_occ", 72'(occA), 72'd0);
    check("rst_pc", 72'(pcOutA), 72'd0);
    check("rst_data", dOutA, 72'd0);
    check("rst_stall", 72'(stallA), 72'd0);
    check("rst_readyB", 72'(rdyOutB), 72'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    tick();

    // Streaming at full throughput
    rdyInA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offerA(32'(i * 4), 1'b1);
      tick();
      check("stream_valid", 72'(vOutA), 72'd1);
      check("stream_pc", 72'(pcOutA), 72'(i * 4));
      check("stream_occ", 72'(occA), 72'd1);
      check("stream_stall", 72'(stallA), 72'd0);
    end
    vInA = 1'b0;
    tick();
    check("stream_drain_occ", 72'(occA), 72'd0);

    // Skid fill and drain
    rdyInA = 1'b0;
    offerA(32'h100, 1'b1);
    tick();
    check("skid_occ1", 72'(occA), 72'd1);
    check("skid_ready1", 72'(rdyOutA), 72'd1);
    offerA(32'h104, 1'b1);
    tick();
    check("skid_occ2", 72'(occA), 72'd2);
    check("skid_ready2", 72'(rdyOutA), 72'd0);
    check("skid_head", 72'(pcOutA), 72'h100);
    vInA = 1'b0;
    tick();
    check("skid_stall_held", 72'(stallA), 72'd2);
    rdyInA = 1'b1;
    tick();
    check("skid_pc_after_issue", 72'(pcOutA), 72'h104);
    check("skid_ready_back", 72'(rdyOutA), 72'd1);
    check("skid_occ_after_issue", 72'(occA), 72'd1);
    tick();
    check("skid_empty", 72'(occA), 72'd0);
    check("skid_stall_final", 72'(stallA), 72'd2);

    // Flush from SKID with an incoming entry and downstream stalled
    rdyInA = 1'b0;
    offerA(32'h200, 1'b1);
    tick();
    offerA(32'h204, 1'b1);
    tick();
    check("flush_pre_occ", 72'(occA), 72'd2);
    check("flush_pre_stall", 72'(stallA), 72'd3);
    offerA(32'h208, 1'b0);
    flushA = 1'b1;
    tick();
    flushA = 1'b0;
    vInA = 1'b0;
    qA.delete();
    check("flush_valid", 72'(vOutA), 72'd0);
    check("flush_occ", 72'(occA), 72'd0);
    check("flush_data", dOutA, 72'd0);
    check("flush_pc", 72'(pcOutA), 72'd0);
    check("flush_stall", 72'(stallA), 72'd3);
    tick();
    check("flush_stays_empty", 72'(vOutA), 72'd0);

    // Flush while the head is issued in the same cycle: the head still counts
    offerA(32'h300, 1'b1);
    tick();
    offerA(32'h304, 1'b0);
    rdyInA = 1'b1;
    flushA = 1'b1;
    tick();
    flushA = 1'b0;
    vInA = 1'b0;
    check("flush_issue_queue", 72'(qA.size()), 72'd0);
    qA.delete();
    check("flush_issue_valid", 72'(vOutA), 72'd0);
    check("flush_issue_stall", 72'(stallA), 72'd3);

    // Single-entry variant: combinational ready and same-cycle replacement
    rdyInB = 1'b0;
    offerB(32'h700);
    tick();
    vInB = 1'b0;
    check("B_occ1", 72'(occB), 72'd1);
    check("B_ready_blocked", 72'(rdyOutB), 72'd0);
    rdyInB = 1'b1;
    #1;
    check("B_ready_comb", 72'(rdyOutB), 72'd1);
    offerB(32'h704);
    tick();
    vInB = 1'b0;
    rdyInB = 1'b0;
    check("B_replace_valid", 72'(vOutB), 72'd1);
    check("B_replace_pc", 72'(pcOutB), 72'h704);
    check("B_replace_occ", 72'(occB), 72'd1);
    #1;
    check("B_ready_low_again", 72'(rdyOutB), 72'd0);
    tick();
    check("B_stall", 72'(stallB), 72'd1);
    rdyInB = 1'b1;
    tick();
    check("B_empty", 72'(occB), 72'd0);
    rdyInB = 1'b0;

    // Stall counter saturation
    rdyInA = 1'b0;
    offerA(32'h400, 1'b1);
    tick();
    vInA = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", 72'(stallA), 72'd15);
    check("sat_valid", 72'(vOutA), 72'd1);
    check("sat_pc", 72'(pcOutA), 72'h400);
    rdyInA = 1'b1;
    tick();
    check("sat_after_issue", 72'(stallA), 72'd15);
    check("sat_empty", 72'(occA), 72'd0);

    // Asynchronous reset between clock edges
    offerA(32'h500, 1'b1);
    tick();
    offerA(32'h504, 1'b1);
    tick();
    vInA = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 72'(vOutA), 72'd0);
    check("arst_pc", 72'(pcOutA), 72'd0);
    check("arst_data", dOutA, 72'd0);
    check("arst_occ", 72'(occA), 72'd0);
    check("arst_stall", 72'(stallA), 72'd0);
    check("arst_ready", 72'(rdyOutA), 72'd1);
    qA.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    offerA(32'h600, 1'b1);
    tick();
    vInA = 1'b0;
    check("arst_first_valid", 72'(vOutA), 72'd1);
    check("arst_first_pc", 72'(pcOutA), 72'h600);
    tick();
    check("arst_drain", 72'(occA), 72'd0);
    tick();

    check("A_queue_empty", 72'(qA.size()), 72'd0);
    check("B_queue_empty", 72'(qB.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage core. Covers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a PC field plus an opaque control+data payload between adjacent stages.
- Adds a valid/ready handshake, stall back-pressure, synchronous flush, an optional 2-entry skid buffer and a saturating stall counter.
- Stage-specific wrappers pack their control and data fields into the payload.

Parameters:
- DATA_W, 72, payload width in bits (packed control + data fields).
- PC_W, 32, PC field width.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered ready_o; 0 = single entry with combinational ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush: drop all held and incoming entries.
- valid_i  in  1  upstream stage presents an entry.
- ready_o  out  1  this stage can accept an entry.
- pc_i  in  PC_W  upstream PC.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  an entry is presented downstream.
- ready_i  in  1  downstream can accept.
- pc_o  out  PC_W  PC of the head entry.
- data_o  out  DATA_W  payload of the head entry.
- occupancy_o  out  2  number of held entries (0..2).
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0.

Behaviour:
- Transfers:
  - Accept = valid_i & ready_o.
  - Issue = valid_o & ready_i.
  - Both are evaluated on the same rising edge of clk.
- Reset (rst=0, asynchronous):
  - State goes to EMPTY.
  - pc_o, data_o, skid registers, occupancy_o and stall_cnt_o all go to 0.
  - valid_o = 0.
  - ready_o = 1 when SKID_EN=1; ready_o = 1 when SKID_EN=0, because valid_o=0.
- States: EMPTY (0 entries), FULL (main register), SKID (main + skid register; exists only if SKID_EN=1).
- Output decode:
  - valid_o = (state != EMPTY).
  - pc_o/data_o always come from the main register.
  - occupancy_o = 0 / 1 / 2 for EMPTY / FULL / SKID.
- Ready generation:
  - SKID_EN=1: ready_o = (state != SKID). It is a function of state only, so there is no combinational ready_i→ready_o path.
  - SKID_EN=0: ready_o = ~valid_o | ready_i (combinational).
- Transitions (flush_i=0):
  - EMPTY:
    - accept → FULL, main <= input.
    - otherwise → hold.
  - FULL:
    - accept & issue → FULL, main <= input.
    - accept & ~issue → SKID, skid <= input. Reachable only with SKID_EN=1; with SKID_EN=0 ready_o forbids it.
    - ~accept & issue → EMPTY.
    - neither → hold; main is unchanged.
  - SKID:
    - issue → FULL, main <= skid.
    - no accept is possible.
- Ordering: strictly FIFO; the skid entry is never issued ahead of main.
- Latency:
  - One cycle from accept to valid_o when EMPTY.
  - Full throughput is 1 entry/cycle while ready_i=1.
- flush_i=1 (highest priority below reset):
  - The next state is EMPTY regardless of valid_i/ready_i.
  - The input offered in the flush cycle is discarded, even if ready_o=1.
  - The main entry is still visible with valid_o=1 during the flush cycle. If downstream accepts it that cycle it counts as issued; flush kills only future cycles.
  - pc/data registers are cleared to 0.
  - stall_cnt_o is not cleared by flush.
- Stall counter:
  - Increments when valid_o & ~ready_i & ~flush_i.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - Cleared only by reset.
- Reset asserted mid-operation: immediate return to the reset values; in-flight entries are lost.
- Payload and PC are not interpreted; all DATA_W/PC_W bits pass through unmodified.

Test Plan:
- Streaming: SKID_EN=1, ready_i=1 constant, valid_i=1 with pc 0x0,0x4,0x8,0xC on consecutive cycles → pc_o shows the same sequence one cycle later, valid_o continuous, occupancy_o=1, stall_cnt_o=0.
- Skid fill: hold ready_i=0, send pc 0x100 then 0x104 → occupancy_o 1 then 2, ready_o=0 after the second accept. Raise ready_i → pc_o=0x100 then 0x104, ready_o returns to 1 after the first issue, stall_cnt_o counts the held cycles exactly.
- Flush: state SKID with 0x200/0x204 and valid_i=1 with 0x208, assert flush_i for one cycle → next cycle valid_o=0, occupancy_o=0, data_o=0. 0x204 and 0x208 are never emitted; stall_cnt_o is unchanged.
- SKID_EN=0: ready_i=0 with one entry held → ready_o=0 combinationally. Pulse ready_i=1 with valid_i=1 → same-cycle replacement, no bubble, occupancy_o stays 1.
- Saturation: CNT_W=4, hold valid_o=1 and ready_i=0 for 20 cycles → stall_cnt_o sticks at 15.
- Async reset: drop rst mid-stream between clock edges → all outputs 0 immediately, without waiting for a clk edge. Release rst → first accepted entry appears after 1 cycle.
